// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, memory word addressing, decode handshake and redirects.
// Define FETCH_ALIGN_CHECK_EN to make misaligned redirects raise a sticky fetch_fault.
module instr_fetch #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 6,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [31:0]           instr_pc,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  fetch_fault
);

    logic [31:0] resp_pc_q, resp_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] issue_pc;

    always_comb begin
        fault_d  = fault_q;
        issue_pc = resp_pc_q;
        if (!rst_n) begin
            issue_pc = RESET_PC;
        end else if (fault_q) begin
            issue_pc = resp_pc_q;
        end else if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            // A misaligned target is never issued; memory keeps reading the current word.
            if (redirect_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
            end else begin
                issue_pc = redirect_pc;
            end
`else
            issue_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
        end else if (!resp_valid_q) begin
            issue_pc = resp_pc_q;
        end else if (instr_ready) begin
            issue_pc = resp_pc_q + 32'd4;
        end
`ifndef FETCH_ALIGN_CHECK_EN
        fault_d = 1'b0;
`endif
        resp_pc_d    = issue_pc;
        resp_valid_d = !fault_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_pc_q    <= RESET_PC;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign imem_addr   = issue_pc[ADDR_WIDTH+1:2];
    assign instr_valid = rst_n & resp_valid_q & !redirect_valid & !fault_q;
    assign instr_pc    = resp_pc_q;
    assign instr_data  = imem_rdata;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
